riscv_alu_offload: RTL and testbench

//  EX-stage companion of the basic ALU in shared-DSP cores. Takes operations the basic ALU does
//  not implement (MIN/MAX/ABS/CLIP*, bit counting, DIV/REM), issues them to the shared DSP cluster

---
 rtl/riscv_alu_offload_pkg.sv | 31 +++
 rtl/riscv_alu_offload.sv | 137 +++++++++++++
 tb/tb_riscv_alu_offload.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_alu_offload_pkg.sv
// Shared ALU opcodes, vector-mode encodings and offload FSM types for the
// EX-stage DSP offload unit.
package riscv_alu_offload_pkg;

  localparam int ALU_OP_WIDTH      = 7;
  localparam int ALU_OFFLOAD_TAG_W = 2;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_MIN   = 7'b0010000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MINU  = 7'b0010001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MAX   = 7'b0010010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MAXU  = 7'b0010011;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ABS   = 7'b0010100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_CLIP  = 7'b0010110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_CLIPU = 7'b0010111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_CNT   = 7'b0110110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV   = 7'b0110001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REM   = 7'b0110011;

  localparam logic [1:0] VEC_MODE32 = 2'b00;
  localparam logic [1:0] VEC_MODE16 = 2'b10;
  localparam logic [1:0] VEC_MODE8  = 2'b11;

  typedef enum logic [2:0] {
    OFL_IDLE,
    OFL_REQ,
    OFL_WAIT,
    OFL_DONE,
    OFL_DRAIN
  } offload_state_e;

endpackage

// File: rtl/riscv_alu_offload.sv
// EX-stage offload of non-basic ALU ops to the shared DSP cluster over a
// tagged req/gnt + rvalid port; holds the result until EX retires it.
module riscv_alu_offload
  import riscv_alu_offload_pkg::*;
#(
  parameter int OP_WIDTH  = ALU_OP_WIDTH,
  parameter int TAG_WIDTH = ALU_OFFLOAD_TAG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic [OP_WIDTH-1:0]  operator_i,
  input  logic [31:0]          operand_a_i,
  input  logic [31:0]          operand_b_i,
  input  logic [31:0]          operand_c_i,
  input  logic [1:0]           vector_mode_i,
  input  logic                 flush_i,
  input  logic                 ex_ready_i,
  output logic [31:0]          result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 resp_err_o,
  output logic                 dsp_req_o,
  input  logic                 dsp_gnt_i,
  output logic [OP_WIDTH-1:0]  dsp_op_o,
  output logic [95:0]          dsp_operands_o,
  output logic [1:0]           dsp_vec_mode_o,
  output logic [TAG_WIDTH-1:0] dsp_tag_o,
  input  logic                 dsp_rvalid_i,
  input  logic [TAG_WIDTH-1:0] dsp_rtag_i,
  input  logic [31:0]          dsp_rdata_i
);

  offload_state_e       state_q, state_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [OP_WIDTH-1:0]  op_q, op_d;
  logic [95:0]          opnd_q, opnd_d;
  logic [1:0]           vec_q, vec_d;
  logic [31:0]          result_q, result_d;
  logic                 kill_q, kill_d;
  logic                 err_q, err_d;

  // The tag advances on grant, so the outstanding transaction is tag_q - 1.
  logic [TAG_WIDTH-1:0] issued_tag;
  logic                 rsp_match;
  logic                 rsp_expected;

  assign issued_tag   = tag_q - TAG_WIDTH'(1);
  assign rsp_match    = dsp_rvalid_i && (dsp_rtag_i == issued_tag);
  assign rsp_expected = rsp_match && ((state_q == OFL_WAIT) || (state_q == OFL_DRAIN));

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    vec_d    = vec_q;
    result_d = result_q;
    kill_d   = kill_q;
    err_d    = dsp_rvalid_i && !rsp_expected;
    unique case (state_q)
      OFL_IDLE: begin
        if (enable_i && !flush_i) begin
          op_d    = operator_i;
          opnd_d  = {operand_c_i, operand_b_i, operand_a_i};
          vec_d   = vector_mode_i;
          kill_d  = 1'b0;
          state_d = OFL_REQ;
        end
      end
      OFL_REQ: begin
        // The request cannot be withdrawn; a flush only marks it for draining.
        if (flush_i) kill_d = 1'b1;
        if (dsp_gnt_i) begin
          tag_d   = tag_q + TAG_WIDTH'(1);
          state_d = (kill_q || flush_i) ? OFL_DRAIN : OFL_WAIT;
        end
      end
      OFL_WAIT: begin
        if (rsp_match) begin
          result_d = dsp_rdata_i;
          state_d  = flush_i ? OFL_IDLE : OFL_DONE;
        end else if (flush_i) begin
          state_d = OFL_DRAIN;
        end
      end
      OFL_DONE: begin
        if (ex_ready_i || flush_i) state_d = OFL_IDLE;
      end
      OFL_DRAIN: begin
        if (rsp_match) state_d = OFL_IDLE;
      end
      default: state_d = OFL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= OFL_IDLE;
      tag_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      vec_q    <= '0;
      result_q <= '0;
      kill_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      vec_q    <= vec_d;
      result_q <= result_d;
      kill_q   <= kill_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    ready_o = 1'b0;
    unique case (state_q)
      OFL_IDLE:             ready_o = !enable_i;
      OFL_DONE, OFL_DRAIN:  ready_o = 1'b1;
      default:              ready_o = 1'b0;
    endcase
  end

  assign result_o       = (state_q == OFL_DONE) ? result_q : 32'd0;
  assign busy_o         = (state_q != OFL_IDLE);
  assign resp_err_o     = err_q;
  assign dsp_req_o      = (state_q == OFL_REQ);
  assign dsp_op_o       = op_q;
  assign dsp_operands_o = opnd_q;
  assign dsp_vec_mode_o = vec_q;
  assign dsp_tag_o      = tag_q;

endmodule

// File: tb/tb_riscv_alu_offload.sv
// Directed bench for riscv_alu_offload: handshake timing, hold, flush/drain,
// tag wrap with stale response, and asynchronous reset mid-transaction.
module tb_riscv_alu_offload;
  import riscv_alu_offload_pkg::*;

  logic        clk, rst;
  logic        enable, flush, ex_ready;
  logic [6:0]  op;
  logic [31:0] a, b, c;
  logic [1:0]  vec;
  logic [31:0] result;
  logic        ready, busy, err;
  logic        req, gnt;
  logic [6:0]  dop;
  logic [95:0] dopnd;
  logic [1:0]  dvec;
  logic [1:0]  dtag;
  logic        rvalid;
  logic [1:0]  rtag;
  logic [31:0] rdata;

  int total = 0;
  int bad   = 0;

  riscv_alu_offload dut (
    .clk(clk), .rst(rst),
    .enable_i(enable), .operator_i(op),
    .operand_a_i(a), .operand_b_i(b), .operand_c_i(c),
    .vector_mode_i(vec), .flush_i(flush), .ex_ready_i(ex_ready),
    .result_o(result), .ready_o(ready), .busy_o(busy), .resp_err_o(err),
    .dsp_req_o(req), .dsp_gnt_i(gnt), .dsp_op_o(dop),
    .dsp_operands_o(dopnd), .dsp_vec_mode_o(dvec), .dsp_tag_o(dtag),
    .dsp_rvalid_i(rvalid), .dsp_rtag_i(rtag), .dsp_rdata_i(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tg, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tg, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One full offload op: capture, granted immediately, optional stale response, then match.
  task automatic run_op(input logic [1:0] etag, input logic [31:0] d, input bit stale);
    logic [1:0] st;
    st = etag - 2'd1;
    enable = 1'b1; op = ALU_CLIP; a = d; b = 32'd0; c = 32'hFFFF; vec = VEC_MODE32; gnt = 1'b1;
    tick();
    enable = 1'b0;
    #1;
    chk("t5_tag", dtag, etag);
    chk("t5_req", req, 1'b1);
    tick();
    gnt = 1'b0;
    if (stale) begin
      rvalid = 1'b1; rtag = st; rdata = 32'hDEAD;
      tick();
      rvalid = 1'b0;
      #1;
      chk("t5_stale_err", err, 1'b1);
      chk("t5_stale_busy", busy, 1'b1);
      chk("t5_stale_ready", ready, 1'b0);
    end
    rvalid = 1'b1; rtag = etag; rdata = d;
    tick();
    rvalid = 1'b0;
    #1;
    chk("t5_ready", ready, 1'b1);
    chk("t5_result", result, d);
    chk("t5_err_clear", err, 1'b0);
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
    #1;
    chk("t5_idle", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    op = '0; a = '0; b = '0; c = '0; vec = '0;
    gnt = 1'b0; rvalid = 1'b0; rtag = '0; rdata = '0;
    #12;
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req", req, 1'b0);
    chk("rst_result", result, 32'd0);
    chk("rst_tag", dtag, 2'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_opnd", dopnd, 96'd0);
    rst = 1'b0;

    // Test 1: MIN 5,-3 with immediate grant, response next cycle
    tick();
    enable = 1'b1; op = ALU_MIN; a = 32'd5; b = 32'hFFFFFFFD; c = 32'd0; vec = VEC_MODE32; gnt = 1'b1;
    #1;
    chk("t1_idle_ready", ready, 1'b0);
    tick();
    enable = 1'b0;
    #1;
    chk("t1_req", req, 1'b1);
    chk("t1_op", dop, ALU_MIN);
    chk("t1_opnd", dopnd, {32'd0, 32'hFFFFFFFD, 32'd5});
    chk("t1_vec", dvec, VEC_MODE32);
    chk("t1_tag", dtag, 2'd0);
    chk("t1_req_ready", ready, 1'b0);
    tick();
    gnt = 1'b0; rvalid = 1'b1; rtag = 2'd0; rdata = 32'hFFFFFFFD;
    #1;
    chk("t1_wait_ready", ready, 1'b0);
    chk("t1_wait_req", req, 1'b0);
    tick();
    rvalid = 1'b0;
    #1;
    chk("t1_done_ready", ready, 1'b1);
    chk("t1_result", result, 32'hFFFFFFFD);
    chk("t1_tag_adv", dtag, 2'd1);
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
    #1;
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_idle_result", result, 32'd0);

    // Test 2: grant withheld for 4 cycles
    enable = 1'b1; op = ALU_DIV; a = 32'd100; b = 32'd7; c = 32'd0; vec = VEC_MODE16; gnt = 1'b0;
    tick();
    enable = 1'b0; a = 32'd1; b = 32'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_req_hold", req, 1'b1);
      chk("t2_opnd_hold", dopnd, {32'd0, 32'd7, 32'd100});
      chk("t2_op_hold", dop, ALU_DIV);
      chk("t2_ready_low", ready, 1'b0);
      tick();
    end
    gnt = 1'b1;
    #1;
    chk("t2_tag", dtag, 2'd1);
    tick();
    gnt = 1'b0; rvalid = 1'b1; rtag = 2'd1; rdata = 32'd14;
    tick();
    rvalid = 1'b0;

    // Test 3: hold result in DONE while EX stalls
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_ready", ready, 1'b1);
      chk("t3_result", result, 32'd14);
      tick();
    end
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
    #1;
    chk("t3_idle", busy, 1'b0);
    chk("t3_result0", result, 32'd0);

    // Test 4: flush in WAIT, response drained
    enable = 1'b1; op = ALU_MAX; a = 32'd9; b = 32'd4; c = 32'd0; vec = VEC_MODE32; gnt = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    gnt = 1'b0; flush = 1'b1;
    #1;
    chk("t4_wait_ready", ready, 1'b0);
    tick();
    flush = 1'b0;
    #1;
    chk("t4_drain_ready", ready, 1'b1);
    chk("t4_drain_busy", busy, 1'b1);
    chk("t4_drain_result", result, 32'd0);
    enable = 1'b1; rvalid = 1'b1; rtag = 2'd2; rdata = 32'h1234;
    tick();
    enable = 1'b0; rvalid = 1'b0;
    #1;
    chk("t4_idle", busy, 1'b0);
    chk("t4_result", result, 32'd0);
    chk("t4_err", err, 1'b0);
    chk("t4_tag", dtag, 2'd3);

    // Test 6: async reset while waiting; late response flagged
    enable = 1'b1; op = ALU_ABS; a = 32'hFFFFFF00; gnt = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    gnt = 1'b0;
    #1;
    chk("t6_wait_busy", busy, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", ready, 1'b1);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_req", req, 1'b0);
    chk("t6_rst_tag", dtag, 2'd0);
    chk("t6_rst_result", result, 32'd0);
    tick();
    chk("t6_edge_busy", busy, 1'b0);
    rst = 1'b0;
    rvalid = 1'b1; rtag = 2'd3; rdata = 32'h55;
    tick();
    rvalid = 1'b0;
    #1;
    chk("t6_late_err", err, 1'b1);
    chk("t6_late_busy", busy, 1'b0);
    tick();
    #1;
    chk("t6_err_pulse", err, 1'b0);

    // Test 5: tag sequence 0,1,2,3,0 with a stale tag-3 response on the wrapped op
    run_op(2'd0, 32'd10, 1'b0);
    run_op(2'd1, 32'd11, 1'b0);
    run_op(2'd2, 32'd12, 1'b0);
    run_op(2'd3, 32'd13, 1'b0);
    run_op(2'd0, 32'd14, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
